// File: rtl/down_timer_pkg.sv
// Shared types for the down-counting timer.
package down_timer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } timer_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Divides enabled cycles into timer ticks: one tick every PRESCALE enabled cycles.
// Compiled only when DOWN_TIMER_PRESCALE_EN is defined.
`ifdef DOWN_TIMER_PRESCALE_EN
module timer_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic run_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = run_i && en_i && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i && en_i) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/down_timer.sv
// Programmable down-counting timer with one-shot / periodic modes and a terminal-count pulse.
// Define DOWN_TIMER_PRESCALE_EN to insert a PRESCALE-cycle tick divider.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             periodic_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic [WIDTH-1:0] value_o,
  output logic             busy_o,
  output logic             tc_o
);

  timer_state_e     state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             tc_q, tc_d;
  logic             tick;

`ifdef DOWN_TIMER_PRESCALE_EN
  timer_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (en_i),
    .run_i (state_q == StRun),
    .clr_i (start_i || stop_i),
    .tick_o(tick)
  );
`else
  assign tick = en_i;
`endif

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    tc_d     = 1'b0;

    if (stop_i) begin
      state_d = StIdle;
    end else if (start_i) begin
      value_d  = load_value_i;
      reload_d = load_value_i;
      mode_d   = periodic_i;
      state_d  = StRun;
    end else if (state_q == StRun && tick) begin
      if (value_q > WIDTH'(1)) begin
        value_d = value_q - WIDTH'(1);
      end else begin
        // Expiry: a load of 0 lands here too, so it behaves as 1.
        tc_d = 1'b1;
        if (mode_q) begin
          value_d = reload_q;
        end else begin
          value_d = '0;
          state_d = StDone;
        end
      end
    end

    busy_d = (state_d == StRun);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      value_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      busy_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      tc_q     <= tc_d;
    end
  end

  assign value_o = value_q;
  assign busy_o  = busy_q;
  assign tc_o    = tc_q;

endmodule
